// File: rtl/counter_seq_ctrl_if.sv
// Handshake/bus bundle between the sequencer and its environment.
// The slave modport is the sequencer side.
interface counter_seq_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             bounce;
  logic [CNT_W-1:0] target_in;
  logic [CNT_W-1:0] count_in;
  logic             flag_in;
  logic             cnt_enb;
  logic             cnt_clr;
  logic             cnt_op;
  logic             busy;
  logic             done;
  logic             err;
  logic [2:0]       state;

  modport master (
    output start, stop, pause, bounce, target_in, count_in, flag_in,
    input  cnt_enb, cnt_clr, cnt_op, busy, done, err, state
  );

  modport slave (
    input  start, stop, pause, bounce, target_in, count_in, flag_in,
    output cnt_enb, cnt_clr, cnt_op, busy, done, err, state
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving an external up/down counter: clear, count up to a target,
// optionally count back down to zero, with prescaled steps, pause and abort.
module counter_seq_ctrl #(
  parameter int unsigned MAX_VALUE = 9,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_seq_ctrl_if.slave  bus
);
  localparam int unsigned PRE_W = 8;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_VALUE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    UP    = 3'd2,
    DOWN  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q;
  logic [CNT_W-1:0] target_q;
  logic             bounce_q;
  logic             ret_down_q;
  logic             err_q;
  logic             done_q;
  logic             running, step, launch, flag_hit;
  logic             enb_c, clr_c, op_c, busy_c;

  assign running  = (state_q == UP) || (state_q == DOWN);
  assign step     = running && (presc_q == PRE_LAST);
  assign flag_hit = running && bus.flag_in && !bus.stop;
  assign launch   = (state_d == CLEAR);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; stop overrides everything, flag overrides the step decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = CLEAR;
      CLEAR:      state_d = UP;
      UP: begin
        if (bus.flag_in)                           state_d = DONE;
        else if (step && bus.count_in == target_q) state_d = bounce_q ? DOWN : DONE;
        else if (bus.pause)                        state_d = PAUSE;
      end
      DOWN: begin
        if (bus.flag_in)                                     state_d = DONE;
        else if (step && bus.count_in == {CNT_W{1'b0}})      state_d = DONE;
        else if (bus.pause)                                  state_d = PAUSE;
      end
      PAUSE:      if (!bus.pause) state_d = ret_down_q ? DOWN : UP;
      default:    state_d = IDLE;
    endcase
    if (bus.stop) state_d = IDLE;
  end

  // Counter control outputs, decoded from state and the step instant
  always_comb begin
    enb_c  = 1'b0;
    clr_c  = 1'b0;
    op_c   = 1'b1;
    busy_c = 1'b0;
    case (state_q)
      CLEAR: begin
        enb_c  = 1'b1;
        clr_c  = 1'b1;
        busy_c = 1'b1;
      end
      UP: begin
        busy_c = 1'b1;
        enb_c  = step && (bus.count_in != target_q);
      end
      DOWN: begin
        busy_c = 1'b1;
        op_c   = 1'b0;
        enb_c  = step && (bus.count_in != {CNT_W{1'b0}});
      end
      PAUSE:   busy_c = 1'b1;
      default: ;
    endcase
  end

  // Prescaler: runs in UP/DOWN, holds across a pause, otherwise parked at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (running && state_d == state_q) begin
      presc_q <= step ? '0 : presc_q + PRE_W'(1);
    end else if (running && state_d == PAUSE) begin
      presc_q <= step ? '0 : presc_q;
    end else if (state_q == PAUSE && state_d != IDLE) begin
      presc_q <= presc_q;
    end else begin
      presc_q <= '0;
    end
  end

  // Sequence context and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q   <= '0;
      bounce_q   <= 1'b0;
      ret_down_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (launch) begin
        target_q <= (bus.target_in > MAX_CNT) ? MAX_CNT : bus.target_in;
        bounce_q <= bus.bounce;
      end
      if (running && state_d == PAUSE) ret_down_q <= (state_q == DOWN);
      if (launch)        err_q <= 1'b0;
      else if (flag_hit) err_q <= 1'b1;
      done_q <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign bus.cnt_enb = enb_c;
  assign bus.cnt_clr = clr_c;
  assign bus.cnt_op  = op_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl paired with a behavioural up/down counter.
module tb_counter_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  int tests = 0;
  int fails = 0;
  int cyc = 0, clears = 0, ups = 0, downs = 0, dones = 0, clear_cyc = 0;
  int up_cyc [16];

  counter_seq_ctrl_if #(.CNT_W(4)) bus ();

  counter_seq_ctrl #(.MAX_VALUE(9), .CNT_W(4), .PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  assign bus.count_in = count;

  // Counter model plus activity statistics
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else begin
      cyc++;
      if (bus.cnt_enb) begin
        if (bus.cnt_clr) begin
          clears++;
          clear_cyc = cyc;
          count <= 4'd0;
        end else if (bus.cnt_op) begin
          if (ups < 16) up_cyc[ups] = cyc;
          ups++;
          count <= count + 4'd1;
        end else begin
          downs++;
          count <= count - 4'd1;
        end
      end
      if (bus.done) dones++;
    end
  end

  task automatic kick(input logic [3:0] tgt, input logic b);
    @(negedge clk);
    bus.target_in = tgt;
    bus.bounce    = b;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.state == s) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (bus.state !== 3'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.cnt_enb !== 1'b0) begin fails++; $display("FAIL rst_enb got=%b exp=0", bus.cnt_enb); end
    tests++; if (bus.cnt_clr !== 1'b0) begin fails++; $display("FAIL rst_clr got=%b exp=0", bus.cnt_clr); end
    tests++; if (bus.cnt_op !== 1'b1) begin fails++; $display("FAIL rst_op got=%b exp=1", bus.cnt_op); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (bus.state !== 3'd0) begin fails++; $display("FAIL idle_hold got=%0d exp=0", bus.state); end
  endtask

  task automatic test_up();
    int u0 = ups, d0 = downs, c0 = clears, n0 = dones;
    bit ok;
    kick(4'd3, 1'b0);
    wait_done(60, ok);
    tests++; if (!ok) begin fails++; $display("FAIL up_timeout got=no_done exp=done"); end
    repeat (6) @(negedge clk);
    tests++; if (ups - u0 !== 3) begin fails++; $display("FAIL up_steps got=%0d exp=3", ups - u0); end
    tests++; if (downs - d0 !== 0) begin fails++; $display("FAIL up_downs got=%0d exp=0", downs - d0); end
    tests++; if (clears - c0 !== 1) begin fails++; $display("FAIL up_clears got=%0d exp=1", clears - c0); end
    tests++; if (count !== 4'd3) begin fails++; $display("FAIL up_count got=%0d exp=3", count); end
    tests++; if (dones - n0 !== 1) begin fails++; $display("FAIL up_done_pulses got=%0d exp=1", dones - n0); end
    tests++; if (bus.state !== 3'd5) begin fails++; $display("FAIL up_state got=%0d exp=5", bus.state); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL up_busy got=%b exp=0", bus.busy); end
    tests++; if (up_cyc[u0] - clear_cyc !== 4) begin fails++; $display("FAIL up_first_lat got=%0d exp=4", up_cyc[u0] - clear_cyc); end
    tests++; if (up_cyc[u0+1] - up_cyc[u0] !== 4) begin fails++; $display("FAIL up_gap1 got=%0d exp=4", up_cyc[u0+1] - up_cyc[u0]); end
    tests++; if (up_cyc[u0+2] - up_cyc[u0+1] !== 4) begin fails++; $display("FAIL up_gap2 got=%0d exp=4", up_cyc[u0+2] - up_cyc[u0+1]); end
  endtask

  task automatic test_bounce();
    int u0 = ups, d0 = downs, c0 = clears;
    bit ok;
    kick(4'd2, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(80, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bnc_timeout got=no_done exp=done"); end
    repeat (4) @(negedge clk);
    tests++; if (ups - u0 !== 2) begin fails++; $display("FAIL bnc_ups got=%0d exp=2", ups - u0); end
    tests++; if (downs - d0 !== 2) begin fails++; $display("FAIL bnc_downs got=%0d exp=2", downs - d0); end
    tests++; if (clears - c0 !== 1) begin fails++; $display("FAIL bnc_clears got=%0d exp=1", clears - c0); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL bnc_count got=%0d exp=0", count); end
    tests++; if (bus.state !== 3'd5) begin fails++; $display("FAIL bnc_state got=%0d exp=5", bus.state); end
  endtask

  task automatic test_pause();
    int u0 = ups, u1;
    bit ok, saw;
    kick(4'd5, 1'b0);
    wait_state(3'd2, 10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pse_no_up got=%0d exp=2", bus.state); end
    repeat (2) @(negedge clk);
    bus.pause = 1'b1;
    u1  = ups;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cnt_enb) saw = 1'b1;
    end
    tests++; if (bus.state !== 3'd4) begin fails++; $display("FAIL pse_state got=%0d exp=4", bus.state); end
    tests++; if (saw !== 1'b0 || ups !== u1) begin fails++; $display("FAIL pse_enb got=%0d exp=0", ups - u1); end
    bus.pause = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 3'd2 || bus.cnt_enb !== 1'b0) begin fails++; $display("FAIL pse_resume got=%0d/%b exp=2/0", bus.state, bus.cnt_enb); end
    @(negedge clk);
    tests++; if (bus.cnt_enb !== 1'b1 || bus.cnt_op !== 1'b1) begin fails++; $display("FAIL pse_step got=%b/%b exp=1/1", bus.cnt_enb, bus.cnt_op); end
    wait_done(80, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pse_timeout got=no_done exp=done"); end
    @(negedge clk);
    tests++; if (count !== 4'd5 || ups - u0 !== 5) begin fails++; $display("FAIL pse_end got=%0d/%0d exp=5/5", count, ups - u0); end
  endtask

  task automatic test_clamp();
    int u0 = ups;
    bit ok;
    kick(4'd12, 1'b0);
    wait_done(120, ok);
    tests++; if (!ok) begin fails++; $display("FAIL clamp_timeout got=no_done exp=done"); end
    @(negedge clk);
    tests++; if (count !== 4'd9) begin fails++; $display("FAIL clamp_count got=%0d exp=9", count); end
    tests++; if (ups - u0 !== 9) begin fails++; $display("FAIL clamp_ups got=%0d exp=9", ups - u0); end
  endtask

  task automatic test_flag_back_to_back();
    int u0 = ups;
    bit ok = 1'b0;
    kick(4'd7, 1'b0);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ups - u0 >= 2) ok = 1'b1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL flag_timeout got=%0d exp=2", ups - u0); end
    bus.flag_in = 1'b1;
    @(negedge clk);
    bus.flag_in = 1'b0;
    tests++; if (bus.state !== 3'd5) begin fails++; $display("FAIL flag_state got=%0d exp=5", bus.state); end
    tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL flag_err got=%b exp=1", bus.err); end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL flag_done got=%b exp=1", bus.done); end
    tests++; if (ups - u0 !== 2) begin fails++; $display("FAIL flag_ups got=%0d exp=2", ups - u0); end
    bus.target_in = 4'd1;
    bus.bounce    = 1'b0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tests++; if (bus.state !== 3'd1 || bus.cnt_clr !== 1'b1) begin fails++; $display("FAIL restart got=%0d/%b exp=1/1", bus.state, bus.cnt_clr); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", bus.err); end
    wait_done(40, ok);
    @(negedge clk);
    tests++; if (!ok || count !== 4'd1) begin fails++; $display("FAIL restart_end got=%0d exp=1", count); end
  endtask

  task automatic test_stop();
    bit ok;
    kick(4'd3, 1'b1);
    wait_state(3'd3, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stop_no_down got=%0d exp=3", bus.state); end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    tests++; if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL stop_idle got=%0d/%b exp=0/0", bus.state, bus.busy); end
    tests++; if (bus.cnt_enb !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL stop_outs got=%b/%b exp=0/0", bus.cnt_enb, bus.done); end
    repeat (5) @(negedge clk);
    tests++; if (bus.state !== 3'd0) begin fails++; $display("FAIL stop_hold got=%0d exp=0", bus.state); end
  endtask

  task automatic test_reset_mid();
    int u0 = ups, u1;
    bit ok = 1'b0;
    kick(4'd8, 1'b0);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ups - u0 >= 1) ok = 1'b1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout got=%0d exp=1", ups - u0); end
    #2 rst = 1'b0;
    #1;
    tests++; if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin fails++; $display("FAIL rmid_state got=%0d/%b exp=0/0", bus.state, bus.busy); end
    tests++; if (bus.cnt_enb !== 1'b0 || bus.cnt_op !== 1'b1) begin fails++; $display("FAIL rmid_outs got=%b/%b exp=0/1", bus.cnt_enb, bus.cnt_op); end
    @(negedge clk);
    rst = 1'b1;
    u1 = ups;
    repeat (20) @(negedge clk);
    tests++; if (ups !== u1 || bus.state !== 3'd0) begin fails++; $display("FAIL rmid_quiet got=%0d/%0d exp=0/0", ups - u1, bus.state); end
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pause     = 1'b0;
    bus.bounce    = 1'b0;
    bus.target_in = 4'd0;
    bus.flag_in   = 1'b0;
    test_reset();
    test_up();
    test_bounce();
    test_pause();
    test_clamp();
    test_flag_back_to_back();
    test_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
